// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared encodings and helpers for the AHB-Lite memory slave:
//   - HTRANS / HSIZE / HRESP encodings
//   - responder FSM state enum
//   - byte_strobe(): HSIZE + word offset -> 4-bit byte-lane strobe
// ---------------------------------------------------------------------------
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_e;

  // Little-endian lane strobe. Only meaningful for legal (aligned) transfers.
  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] offset);
    logic [3:0] strobe;
    case (size)
      HSIZE_BYTE: strobe = 4'b0001 << offset;
      HSIZE_HALF: strobe = offset[1] ? 4'b1100 : 4'b0011;
      default:    strobe = 4'b1111;
    endcase
    return strobe;
  endfunction

endpackage

// File: rtl/ahb_lite_mem_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_lite_mem_slave_if
// AHB-Lite signal bundle between the interconnect and one memory slave.
//   master modport : interconnect side (drives HSEL, address/control, HWDATA
//                    and the muxed bus-level HREADY; receives responses)
//   slave  modport : responder side (HRDATA, HREADYOUT, HRESP outputs)
// ---------------------------------------------------------------------------
interface ahb_lite_mem_slave_if #(
  parameter int WIDTH = 32
);
  logic             HSEL;
  logic [WIDTH-1:0] HADDR;
  logic [1:0]       HTRANS;
  logic             HWRITE;
  logic [2:0]       HSIZE;
  logic [WIDTH-1:0] HWDATA;
  logic             HREADY;
  logic [WIDTH-1:0] HRDATA;
  logic             HREADYOUT;
  logic             HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_slave_mem_array.sv
// ---------------------------------------------------------------------------
// ahb_slave_mem_array
// 2^ADDR_BITS x WIDTH word memory with a synchronous byte-enable write port
// and a combinational read port. Contents are never reset.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write word index
//   i_be    : byte-lane enables for the write
//   i_wdata : write data (full word, lanes selected by i_be)
//   i_raddr : read word index
//   o_rdata : read data (combinational)
// ---------------------------------------------------------------------------
module ahb_slave_mem_array #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [WIDTH/8-1:0]   i_be,
  input  logic [WIDTH-1:0]     i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [WIDTH-1:0]     o_rdata
);

  logic [WIDTH-1:0] r_mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < WIDTH / 8; b++) begin
        if (i_be[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_mem_slave
// AHB-Lite word-addressed memory responder with configurable wait states,
// byte/halfword/word writes, read-after-write forwarding and an optional
// two-cycle ERROR response.
//
// Ports:
//   HCLK   : bus clock, everything on posedge
//   HRESET : synchronous active-high reset
//   bus    : ahb_lite_mem_slave_if.slave (HSEL, HADDR, HTRANS, HWRITE, HSIZE,
//            HWDATA, HREADY in; HRDATA, HREADYOUT, HRESP out)
//
// Parameters:
//   WIDTH       : data/address width (lane logic assumes 32)
//   ADDR_BITS   : log2 memory depth in words
//   WAIT_STATES : HREADYOUT-low cycles per OKAY data phase (0..15)
//
// Build option:
//   AHB_SLV_ERR_EN : when defined, illegal transfers (bad size, misaligned,
//   out of range) get the ERR1/ERR2 ERROR response. When undefined they get
//   a normal OKAY response; writes are dropped and reads return 0.
// ---------------------------------------------------------------------------
module ahb_lite_mem_slave
  import ahb_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 0
) (
  input logic                HCLK,
  input logic                HRESET,
  ahb_lite_mem_slave_if.slave bus
);

  localparam logic [3:0] WS_LOAD  = 4'(WAIT_STATES);
  localparam bit         HAS_WAIT = (WAIT_STATES != 0);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [3:0]             r_wait_cnt;
  logic [3:0]             w_wait_cnt_next;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [1:0]             r_off;
  logic                   r_write;
  logic [2:0]             r_size;
  logic                   r_illegal;
  logic                   r_pend;
  logic [WIDTH-1:0]       r_hrdata;

  logic                   w_accept;
  logic                   w_illegal;
  logic                   w_misalign;
  logic [23:0]            w_addr_hi;
  logic                   w_err_accept;
  logic                   w_ok_accept;
  logic                   w_final;
  logic                   w_commit;
  logic [3:0]             w_strobe;
  logic [WIDTH-1:0]       w_wr_mask;
  logic [ADDR_BITS-1:0]   w_rd_addr;
  logic [WIDTH-1:0]       w_rd_data;
  logic                   w_fwd_hit;
  logic                   w_load_now;
  logic                   w_load_bad;
  logic [WIDTH-1:0]       w_load_data;
  logic                   w_hreadyout;
  logic                   w_hresp;
  logic                   w_unused;

  // Decoder owns the top address byte; HTRANS[0] (SEQ vs NONSEQ) is irrelevant here.
  assign w_unused = ^{bus.HADDR[WIDTH-1:24], bus.HTRANS[0]};

  // ---------------- address-phase decode ----------------
  assign w_accept   = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign w_misalign = ((bus.HSIZE == HSIZE_HALF) & bus.HADDR[0]) |
                      ((bus.HSIZE == HSIZE_WORD) & (|bus.HADDR[1:0]));
  assign w_addr_hi  = bus.HADDR[23:0] >> (ADDR_BITS + 2);
  assign w_illegal  = (bus.HSIZE > HSIZE_WORD) | w_misalign | (|w_addr_hi);

`ifdef AHB_SLV_ERR_EN
  assign w_err_accept = w_accept & w_illegal;
`else
  assign w_err_accept = 1'b0;
`endif
  assign w_ok_accept = w_accept & ~w_err_accept;

  // ---------------- data phase / memory ----------------
  // The cycle after the last wait (or after acceptance with no waits) is the
  // final data phase: state is back in IDLE with a transfer still pending.
  assign w_final  = r_pend & (r_state == S_IDLE);
  // Reset wins over a write finishing on the same edge.
  assign w_commit = w_final & r_write & ~r_illegal & ~HRESET;
  assign w_strobe = byte_strobe(r_size, r_off);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
    assign w_wr_mask[gi*8 +: 8] = {8{w_strobe[gi]}};
  end

  // Zero-wait reads load on the acceptance edge, so they address the memory
  // straight from the bus; waited reads load from the latched address.
  assign w_rd_addr = (r_state == S_WAIT) ? r_addr : bus.HADDR[ADDR_BITS+1:2];

  ahb_slave_mem_array #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk     (HCLK),
    .i_we    (w_commit),
    .i_waddr (r_addr),
    .i_be    (w_strobe),
    .i_wdata (bus.HWDATA),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  generate
    if (HAS_WAIT) begin : g_load_wait
      assign w_load_now = (r_state == S_WAIT) & (r_wait_cnt == 4'd1) & ~r_write;
      assign w_load_bad = r_illegal;
    end else begin : g_load_nowait
      assign w_load_now = w_ok_accept & ~bus.HWRITE;
      assign w_load_bad = w_illegal;
    end
  endgenerate

  // A write finishing on the same edge as this read's load is merged in so
  // the read sees the bytes that are only now landing in the array.
  assign w_fwd_hit   = w_commit & (r_addr == w_rd_addr);
  assign w_load_data = w_load_bad ? '0 :
                       w_fwd_hit  ? ((w_rd_data & ~w_wr_mask) | (bus.HWDATA & w_wr_mask)) :
                                    w_rd_data;

  // ---------------- FSM next state / outputs ----------------
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_hreadyout     = 1'b1;
    w_hresp         = HRESP_OKAY;
    case (r_state)
      S_IDLE: begin
`ifdef AHB_SLV_ERR_EN
        if (w_err_accept) begin
          w_state_next = S_ERR1;
        end else
`endif
        if (w_ok_accept && HAS_WAIT) begin
          w_state_next    = S_WAIT;
          w_wait_cnt_next = WS_LOAD;
        end
      end
      S_WAIT: begin
        w_hreadyout = 1'b0;
        if (r_wait_cnt <= 4'd1) begin
          w_state_next    = S_IDLE;
          w_wait_cnt_next = 4'd0;
        end else begin
          w_wait_cnt_next = r_wait_cnt - 4'd1;
        end
      end
`ifdef AHB_SLV_ERR_EN
      S_ERR1: begin
        w_hreadyout  = 1'b0;
        w_hresp      = HRESP_ERROR;
        w_state_next = S_ERR2;
      end
      S_ERR2: begin
        // HREADYOUT is high here, so the next transfer can already start.
        w_hresp = HRESP_ERROR;
        if (w_err_accept) begin
          w_state_next = S_ERR1;
        end else if (w_ok_accept && HAS_WAIT) begin
          w_state_next    = S_WAIT;
          w_wait_cnt_next = WS_LOAD;
        end else begin
          w_state_next = S_IDLE;
        end
      end
`endif
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------- state and datapath registers ----------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_pend     <= 1'b0;
      r_hrdata   <= '0;
      r_addr     <= '0;
      r_off      <= 2'd0;
      r_write    <= 1'b0;
      r_size     <= 3'd0;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_accept) begin
        r_addr    <= bus.HADDR[ADDR_BITS+1:2];
        r_off     <= bus.HADDR[1:0];
        r_write   <= bus.HWRITE;
        r_size    <= bus.HSIZE;
        r_illegal <= w_illegal;
        // ERROR transfers have no data phase of their own to complete.
        r_pend    <= ~w_err_accept;
      end else if (w_final) begin
        r_pend <= 1'b0;
      end
      if (w_load_now) begin
        r_hrdata <= w_load_data;
      end
    end
  end

  assign bus.HRDATA    = r_hrdata;
  assign bus.HREADYOUT = w_hreadyout;
  assign bus.HRESP     = w_hresp;

endmodule
